// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of arbitrations fetch has lost; a fetch grant clears it.
module mem_arb_starve_cnt #(
  parameter int MAX = 3,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic sat;
  assign sat = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (!reset)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory shared between fetch and data requesters, one transaction at a time.
// Optional wait-cycle counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_wait_cnt,
  output logic [31:0]       d_wait_cnt
`endif
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_cnt;
  logic          starved, if_win, d_win, fetch_kill, done_i, done_d;

  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign if_win  = if_req && (!d_req || starved);
  assign d_win   = d_req && !if_win;
  assign done_i  = (state_q == BUSY_I) && mem_ready;
  assign done_d  = (state_q == BUSY_D) && mem_ready;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:           if (if_win) state_d = BUSY_I;
                      else if (d_win) state_d = BUSY_D;
      BUSY_I, BUSY_D: if (mem_ready) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_comb begin
    if_gnt = (state_q == IDLE) && if_win;
    d_gnt  = (state_q == IDLE) && d_win;
    mem_en = (state_q != IDLE);
    busy   = (state_q != IDLE);
  end

  mem_arb_starve_cnt #(.MAX(STARVE_MAX), .W(SW)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (if_req && d_gnt),
    .clr   (if_gnt),
    .cnt   (starve_cnt)
  );

  // Command is captured at grant and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (if_gnt) begin
      mem_we    <= 1'b0;
      mem_be    <= FETCH_BE;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
    end else if (d_gnt) begin
      mem_we    <= d_we;
      mem_be    <= d_be;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end
  end

  // A flush landing on the completion cycle itself still kills the fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_kill <= 1'b0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
    end else begin
      if (done_i)                                     fetch_kill <= 1'b0;
      else if (flush && (if_gnt || state_q == BUSY_I)) fetch_kill <= 1'b1;
      if_valid <= done_i && !fetch_kill && !flush;
      if (done_i && !fetch_kill && !flush) if_rdata <= mem_rdata;
      d_valid <= done_d;
      if (done_d) d_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_wait_cnt <= '0;
      d_wait_cnt  <= '0;
    end else begin
      if (if_req && !if_gnt && state_q != BUSY_I) if_wait_cnt <= if_wait_cnt + 32'd1;
      if (d_req && !d_gnt && state_q != BUSY_D)   d_wait_cnt  <= d_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, flush = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] if_wait_cnt, d_wait_cnt;
`endif

  always #5 clk = ~clk;

  // Memory model: word array indexed by address bits [9:2].
  logic [31:0] mem_arr [256];
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .flush(flush),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
`ifdef MEM_ARB_PERF_CNT_EN
    , .if_wait_cnt(if_wait_cnt), .d_wait_cnt(d_wait_cnt)
`endif
  );

  int vecs = 0, errs = 0;

  // Reference: owner of the port (0 none, 1 fetch, 2 data), lost-arbitration count, command, results.
  int          m_own = 0, m_lost = 0;
  bit          m_kill = 0, m_ifv = 0, m_dv = 0, m_we = 0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0, m_wd = '0, m_ifr = '0, m_dr = '0;
  logic [31:0] m_ifw = '0, m_dw = '0;
  bit          g_if, g_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    bit e_ig, e_dg;
    logic [31:0] rd;
    @(negedge clk);
    e_ig = (m_own == 0) && if_req && (!d_req || m_lost >= SMAX);
    e_dg = (m_own == 0) && d_req && !e_ig;
    chk("ctrl{ig,dg,en,we,busy,iv,dv}",
        32'({if_gnt, d_gnt, mem_en, mem_we, busy, if_valid, d_valid}),
        32'({e_ig, e_dg, m_own != 0, m_we, m_own != 0, m_ifv, m_dv}));
    chk("mem_be", 32'(mem_be), 32'(m_be));
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wd);
    chk("if_rdata", if_rdata, m_ifr);
    chk("d_rdata", d_rdata, m_dr);
`ifdef MEM_ARB_PERF_CNT_EN
    chk("if_wait_cnt", if_wait_cnt, m_ifw);
    chk("d_wait_cnt", d_wait_cnt, m_dw);
`endif
    @(posedge clk);
    #1;
    g_if = e_ig;
    g_d  = e_dg;
    rd = mem_arr[m_addr[9:2]];
    if (m_own == 2 && mem_ready && m_we)
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem_arr[m_addr[9:2]][8*b +: 8] = m_wd[8*b +: 8];
    if (!reset) begin
      m_own = 0; m_lost = 0; m_kill = 0; m_ifv = 0; m_dv = 0; m_we = 0;
      m_be = '0; m_addr = '0; m_wd = '0; m_ifr = '0; m_dr = '0; m_ifw = '0; m_dw = '0;
    end else begin
      if (if_req && !e_ig && m_own != 1) m_ifw++;
      if (d_req && !e_dg && m_own != 2)  m_dw++;
      m_ifv = 0;
      m_dv  = 0;
      if (e_ig) begin
        m_own = 1; m_kill = flush; m_lost = 0;
        m_we = 0; m_be = 4'hF; m_addr = if_addr; m_wd = '0;
      end else if (e_dg) begin
        m_own = 2;
        if (if_req && m_lost < SMAX) m_lost++;
        m_we = d_we; m_be = d_be; m_addr = d_addr; m_wd = d_wdata;
      end else if (m_own == 1 && mem_ready) begin
        if (!(m_kill || flush)) begin m_ifv = 1; m_ifr = rd; end
        m_own = 0; m_kill = 0;
      end else if (m_own == 2 && mem_ready) begin
        m_dv = 1; m_dr = rd; m_own = 0;
      end else if (m_own == 1 && flush) begin
        m_kill = 1;
      end
    end
  endtask

  initial begin
    int first_if, n_dg;
    logic [31:0] base;
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    mem_arr[0] = 32'h2408_0001;   // fetch address 0x3000
    mem_arr[8] = 32'hA5A5_0020;   // fetch address 0x20
    mem_arr[16] = 32'hDEAD_BEEF;  // fetch address 0x40 (flushed)

    // Reset state
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;

    // Fetch-only
    if_req = 1; if_addr = 32'h0000_3000; mem_ready = 1;
    cyc(); if_req = 0;
    cyc(); cyc();
    chk("fetch_only_rdata", if_rdata, 32'h2408_0001);

    // Both requesting: data store first, fetch next IDLE
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h10; d_wdata = 32'h1122_3344;
    if_req = 1; if_addr = 32'h20;
    cyc();
    chk("both_we_be", 32'({mem_we, mem_be}), 32'h13);
    d_req = 0; d_we = 0;
    cyc(); cyc(); if_req = 0;
    cyc(); cyc();
    chk("both_if_rdata", if_rdata, 32'hA5A5_0020);

    // Starvation: fetch wins on the 4th arbitration
    d_req = 1; d_addr = 32'h80; if_req = 1; if_addr = 32'h20;
    first_if = -1; n_dg = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (g_d && first_if < 0) n_dg++;
      if (g_if && first_if < 0) begin first_if = i; if_req = 0; end
    end
    d_req = 0;
    cyc(); cyc();
    chk("starve_first_if_gnt", 32'(first_if), 32'd6);
    chk("starve_d_grants", 32'(n_dg), 32'd3);

    // Flush during BUSY_I with 3 wait cycles
    mem_ready = 0; if_req = 1; if_addr = 32'h40;
    cyc(); if_req = 0; flush = 1;
    cyc(); flush = 0;
    cyc(); cyc();
    mem_ready = 1; cyc();
    mem_ready = 0; cyc();
    chk("flush_keep_rdata", if_rdata, 32'hA5A5_0020);
    chk("flush_busy", 32'(busy), 32'd0);

    // Reset mid data transaction
    d_req = 1; d_addr = 32'h84;
    cyc(); d_req = 0;
    cyc();
    reset = 0; cyc(); reset = 1;
    chk("rst_mid_busy_en", 32'({busy, mem_en}), 32'd0);
    mem_ready = 1; cyc(); cyc();

`ifdef MEM_ARB_PERF_CNT_EN
    mem_ready = 0; base = if_wait_cnt;
    d_req = 1; d_addr = 32'h88; if_req = 1; if_addr = 32'h20;
    cyc(); d_req = 0;
    cyc(); cyc(); cyc();
    mem_ready = 1; cyc();
    mem_ready = 0; cyc(); if_req = 0;
    mem_ready = 1; cyc(); cyc();
    chk("perf_if_wait", if_wait_cnt - base, 32'd5);
`else
    base = '0;
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (g_if) if_req = 0;
      if (g_d)  d_req  = 0;
      if (!if_req && $urandom_range(0, 9) < 4) begin
        if_req = 1; if_addr = $urandom;
      end else if (if_req && $urandom_range(0, 99) < 3) if_req = 0;
      if (!d_req && $urandom_range(0, 9) < 4) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1; d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end else if (d_req && $urandom_range(0, 99) < 3) d_req = 0;
      mem_ready = $urandom_range(0, 1) == 1;
      flush = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 99) != 0;
      cyc();
    end
    reset = 1; if_req = 0; d_req = 0; flush = 0; mem_ready = 1;
    cyc(); cyc(); cyc();
    chk("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sits between the pipeline and the memory.
- Grants one transaction at a time and holds the command stable until the memory reports completion.
- Returns read data to the owning requester; a flush input discards an in-flight fetch result after an exception, interrupt or eret redirect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 3, consecutive lost arbitrations after which fetch wins over data.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse; fetch request accepted.
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store.
- d_be  in  4  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse; data request accepted.
- d_valid  out  1  one-cycle pulse; load data valid, or store done.
- d_rdata  out  DATA_W  load data.
- flush  in  1  discard the pending or in-flight fetch result.
- mem_en  out  1  memory command valid.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  in  1  command completes this cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, starve_cnt=0, fetch_kill=0.
  - All outputs 0, including rdata registers and mem_* command registers.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration, evaluated each cycle:
  - Data wins if d_req=1, unless starve_cnt==STARVE_MAX and if_req=1; then fetch wins.
  - With no data request, fetch wins if if_req=1.
- Grant:
  - The winner's gnt pulses combinationally in that same IDLE cycle.
  - The command (addr/we/be/wdata) is latched into the mem_* registers at the clock edge.
  - Next state is BUSY_I or BUSY_D.
  - Fetch commands drive mem_we=0 and mem_be=4'hF.
- BUSY_x:
  - mem_en=1 and mem_* stay constant until mem_ready=1.
  - On the mem_ready edge: state returns to IDLE, x_rdata<=mem_rdata, x_valid=1 for exactly the next cycle.
- Latency and throughput:
  - Grant to first mem_en is 1 cycle.
  - Minimum grant-to-valid is 2 cycles.
  - Minimum back-to-back is one transaction per 2 cycles, because IDLE always lasts one cycle.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when if_req=1 and d_gnt fires.
  - Clears when if_gnt fires.
- flush:
  - If flush=1 while in BUSY_I, or in the same cycle as if_gnt: set fetch_kill.
  - The memory transaction still completes, but if_valid is suppressed and if_rdata is not updated.
  - fetch_kill clears on return to IDLE.
  - flush has no effect on BUSY_D or on idle cycles.
  - flush does not suppress if_gnt.
- Simultaneous events:
  - mem_ready arriving in the same cycle as new requests is not granted; requests are granted in the following IDLE cycle.
  - Requests that drop before grant are simply not serviced.
- Reset mid-transaction: the FSM is forced to IDLE; no valid is produced for the abandoned transaction.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- With the macro:
  - Adds outputs if_wait_cnt[31:0] and d_wait_cnt[31:0].
  - Each counts cycles where x_req=1 and there is no x_gnt and no transaction of that requester in progress.
  - Counters reset to 0 and wrap at 2^32.
- Without the macro: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2).
  - Fetch byte-enable constant 4'hF.
- One sub-module is natural: mem_arb_starve_cnt, the saturating counter with clear.
- All other logic stays inline.

Test Plan:
- Fetch-only request: if_req=1, if_addr=32'h0000_3000, mem_ready on the 1st BUSY cycle with rdata=32'h2408_0001.
  - Required response: if_gnt at cycle0, mem_en cycle1, if_valid cycle2, if_rdata=32'h2408_0001.
- Both requesting: d_req=1 and if_req=1 in the same cycle.
  - d_gnt first; store with d_be=4'b0011 drives mem_we=1, mem_be=4'b0011.
  - Fetch is granted in the next IDLE cycle.
- Starvation: d_req held high continuously with if_req=1 and STARVE_MAX=3.
  - Three data grants, then if_gnt on the 4th arbitration; starve_cnt returns to 0.
- Flush: flush=1 during BUSY_I with 3 wait cycles (mem_ready low 3 cycles).
  - No if_valid; if_rdata keeps its old value; busy drops after mem_ready.
- Mid-transaction reset: reset=0 in BUSY_D.
  - Next cycle: state IDLE, busy=0, mem_en=0, d_valid never pulses.
- MEM_ARB_PERF_CNT_EN defined: if_req held 5 cycles while a data transaction with 3 wait cycles is running.
  - if_wait_cnt equals the exact count of non-granted cycles (5).
